// File: rtl/softmax_pkg.sv
// -----------------------------------------------------------------------------
// softmax_pkg
// Shared types and constants for the softmax engine arbiter and its bench.
//   DW / MAT_ELEMS / MAT_W : element width, elements per 4x4 matrix, matrix width
//   fp32_t / mat_t         : one IEEE-754 single, a packed 4x4 matrix (X00 at [0])
//   arb_state_e            : arbiter FSM states
//   FP32_QUARTER/FP32_ZERO : reference FP32 encodings (0.25 and +0.0)
// -----------------------------------------------------------------------------
package softmax_pkg;

   localparam int DW        = 32;
   localparam int MAT_ELEMS = 16;
   localparam int MAT_W     = MAT_ELEMS * DW;

   typedef logic [DW-1:0]               fp32_t;
   typedef fp32_t [MAT_ELEMS-1:0]       mat_t;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP
   } arb_state_e;

   localparam fp32_t FP32_QUARTER = 32'h3E80_0000;
   localparam fp32_t FP32_ZERO    = 32'h0000_0000;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set request bit searching
// upward from rr_ptr, wrapping modulo NREQ.
//   req    in  NREQ  request vector
//   rr_ptr in  PW    highest-priority index for this pick
//   any    out 1     at least one request is set
//   pick   out PW    index of the selected request
//   onehot out NREQ  one-hot form of pick (all zero when any=0)
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic            any,
   output logic [PW-1:0]   pick,
   output logic [NREQ-1:0] onehot
);

   // NOTE: every output of a combinational block gets a default before any
   // branch, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      int idx;
      idx  = 0;
      any  = 1'b0;
      pick = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr_ptr) + i) % NREQ;
         if (!any && req[idx]) begin
            any  = 1'b1;
            pick = PW'(idx);
         end
      end
      onehot = any ? (NREQ'(1) << pick) : '0;
   end

endmodule

// File: rtl/softmax_engine_arbiter.sv
// -----------------------------------------------------------------------------
// softmax_engine_arbiter
// Shares one 4x4 row-wise softmax engine among NREQ requesters. A round-robin
// pick in IDLE captures the winner's matrix, LAUNCH pulses the engine start,
// WAIT holds the operand until the engine reports done, and RESP returns the
// captured result with a one-hot strobe. Data passes through unmodified.
//
// Optional feature macro: SOFTMAX_ARB_TIMEOUT_EN
//   Adds a WAIT-state watchdog of TIMEOUT cycles and the rsp_err output.
//
// Ports:
//   clk        in   1          clock
//   rst        in   1          synchronous active-high reset (shared with engine)
//   req        in   NREQ       per-requester job request (level)
//   req_mat    in   NREQ*16*DW requester i at [i*16*DW +: 16*DW], X00 in LSBs
//   gnt        out  NREQ       one-hot, one cycle: job accepted, matrix captured
//   rsp_valid  out  NREQ       one-hot, one cycle: result for that requester
//   rsp_y      out  16*DW      last captured result, Y00 in LSBs
//   rsp_err    out  1          (feature only) RESP caused by watchdog expiry
//   busy       out  1          high in every state except IDLE
//   eng_start  out  1          engine start pulse
//   eng_x      out  16*DW      engine operand, held from x_reg
//   eng_done   in   1          engine done_all
//   eng_y      in   16*DW      engine result
// -----------------------------------------------------------------------------
module softmax_engine_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = softmax_pkg::DW,
   parameter int TIMEOUT = 2000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*16*DW-1:0]  req_mat,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [16*DW-1:0]       rsp_y,
`ifdef SOFTMAX_ARB_TIMEOUT_EN
   output logic                   rsp_err,
`endif
   output logic                   busy,
   output logic                   eng_start,
   output logic [16*DW-1:0]       eng_x,
   input  logic                   eng_done,
   input  logic [16*DW-1:0]       eng_y
);

   import softmax_pkg::*;

   localparam int MW = MAT_ELEMS * DW;
   localparam int PW = $clog2(NREQ);

   arb_state_e      state_q, state_d;
   logic [PW-1:0]   id_q, rr_ptr_q, pick_idx;
   logic [NREQ-1:0] oh_q, pick_oh;
   logic            pick_any;
   logic [MW-1:0]   x_reg, y_reg;

`ifdef SOFTMAX_ARB_TIMEOUT_EN
   logic [31:0]     wd_cnt;
   logic            err_q;
   logic            wd_expired;

   // The counter is 0 on the first WAIT cycle, so expiry at TIMEOUT-1 puts
   // RESP exactly TIMEOUT cycles after WAIT entry.
   assign wd_expired = (wd_cnt == 32'(TIMEOUT - 1));
`endif

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .any    (pick_any),
      .pick   (pick_idx),
      .onehot (pick_oh)
   );

   // Next state and the state-decoded strobes.
   always_comb begin
      state_d   = state_q;
      gnt       = '0;
      rsp_valid = '0;
      eng_start = 1'b0;
      case (state_q)
         IDLE:   if (pick_any) state_d = LAUNCH;
         // eng_done is not looked at here: it may still be the previous job's.
         LAUNCH: begin
            gnt       = oh_q;
            eng_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
`ifdef SOFTMAX_ARB_TIMEOUT_EN
            if (eng_done || wd_expired) state_d = RESP;
`else
            if (eng_done) state_d = RESP;
`endif
         end
         RESP: begin
            rsp_valid = oh_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign eng_x = x_reg;
   assign rsp_y = y_reg;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
   assign rsp_err = (state_q == RESP) && err_q;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the wide data registers are reset too, because the reset state
         // of rsp_y and eng_x is observable and must read as zero.
         state_q  <= IDLE;
         id_q     <= '0;
         oh_q     <= '0;
         rr_ptr_q <= '0;
         x_reg    <= '0;
         y_reg    <= '0;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
         wd_cnt   <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  id_q  <= pick_idx;
                  oh_q  <= pick_oh;
                  x_reg <= req_mat[int'(pick_idx)*MW +: MW];
               end
            end
`ifdef SOFTMAX_ARB_TIMEOUT_EN
            LAUNCH: begin
               wd_cnt <= '0;
               err_q  <= 1'b0;
            end
            WAIT: begin
               wd_cnt <= wd_cnt + 32'd1;
               if (eng_done) begin
                  y_reg <= eng_y;
               end else if (wd_expired) begin
                  y_reg <= '0;
                  err_q <= 1'b1;
               end
            end
`else
            WAIT: begin
               if (eng_done) y_reg <= eng_y;
            end
`endif
            RESP: begin
               // The requester just served drops to lowest priority.
               rr_ptr_q <= (id_q == PW'(NREQ - 1)) ? '0 : id_q + PW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_engine_arbiter.sv
// -----------------------------------------------------------------------------
// tb_softmax_engine_arbiter
// Directed bench for softmax_engine_arbiter with a behavioural engine stub.
// The stub answers L cycles after start: a row whose four elements are equal
// becomes 0.25 x4 (exact softmax of a uniform row); any other row comes back
// with each element's bit pattern incremented by one, which makes routing and
// stale-data errors visible. Inputs change on negedge, outputs are sampled on
// negedge. With SOFTMAX_ARB_TIMEOUT_EN the DUT gets TIMEOUT=50.
// -----------------------------------------------------------------------------
module tb_softmax_engine_arbiter;

   import softmax_pkg::*;

   localparam int NREQ = 4;
   localparam int L    = 3;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
   localparam int TO   = 50;
`else
   localparam int TO   = 2000000;
`endif

   // Row {0, 0.5, 1, 2} and friends, X00 in the LSBs; expected rows by hand.
   localparam logic [127:0] ROW_A   = 128'h40000000_3F800000_3F000000_00000000;
   localparam logic [127:0] ROW_A_Y = 128'h40000001_3F800001_3F000001_00000001;
   localparam logic [127:0] ROW_ONE = 128'h3F800000_3F800000_3F800000_3F800000;
   localparam logic [127:0] ROW_D   = 128'h41200000_40A00000_40000000_3F800000;
   localparam logic [127:0] ROW_D_Y = 128'h41200001_40A00001_40000001_3F800001;
   localparam logic [127:0] ROW_Q   = {4{FP32_QUARTER}};
   localparam logic [127:0] ROW_Z   = {4{FP32_ZERO}};

   localparam logic [MAT_W-1:0] MAT_A = {4{ROW_A}};
   localparam logic [MAT_W-1:0] Y_A   = {4{ROW_A_Y}};
   localparam logic [MAT_W-1:0] MAT_B = {ROW_A, ROW_A, ROW_A, ROW_Z};
   localparam logic [MAT_W-1:0] Y_B   = {ROW_A_Y, ROW_A_Y, ROW_A_Y, ROW_Q};
   localparam logic [MAT_W-1:0] MAT_U = {4{ROW_ONE}};
   localparam logic [MAT_W-1:0] Y_U   = {4{ROW_Q}};
   localparam logic [MAT_W-1:0] MAT_D = {4{ROW_D}};
   localparam logic [MAT_W-1:0] Y_D   = {4{ROW_D_Y}};

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NREQ-1:0]          req;
   logic [NREQ*MAT_W-1:0]    req_mat;
   logic [NREQ-1:0]          gnt, rsp_valid;
   logic [MAT_W-1:0]         rsp_y, eng_x, eng_y;
   logic                     busy, eng_start, eng_done;
`ifdef SOFTMAX_ARB_TIMEOUT_EN
   logic                     rsp_err;
`endif

   always #5 clk = ~clk;

   softmax_engine_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_mat   (req_mat),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
`ifdef SOFTMAX_ARB_TIMEOUT_EN
      .rsp_err   (rsp_err),
`endif
      .busy      (busy),
      .eng_start (eng_start),
      .eng_x     (eng_x),
      .eng_done  (eng_done),
      .eng_y     (eng_y)
   );

   // ---------------- engine stub ----------------
   function automatic mat_t stub_engine(input mat_t x);
      mat_t y;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (x[4*r] == x[4*r+1] && x[4*r] == x[4*r+2] && x[4*r] == x[4*r+3])
               y[4*r+c] = FP32_QUARTER;
            else
               y[4*r+c] = x[4*r+c] + 32'd1;
         end
      end
      return y;
   endfunction

   int   eng_cnt = 0;
   bit   eng_hang = 1'b0;
   mat_t eng_y_q = '0;

   always @(posedge clk) begin
      if (rst) begin
         eng_cnt <= 0;
      end else if (eng_start) begin
         eng_cnt <= L;
         eng_y_q <= stub_engine(eng_x);
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
      end
   end

   // done_all lands in the cycle start+L.
   assign eng_done = (eng_cnt == 1) && !eng_hang;
   assign eng_y    = eng_y_q;

   // ---------------- event monitors ----------------
   int cyc = 0;
   int start_count = 0;
   int gnt_hits [NREQ] = '{default: 0};
   int rsp_hits [NREQ] = '{default: 0};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (eng_start) start_count <= start_count + 1;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i])       gnt_hits[i] <= gnt_hits[i] + 1;
         if (rsp_valid[i]) rsp_hits[i] <= rsp_hits[i] + 1;
      end
   end

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [MAT_W-1:0] act,
                        input logic [MAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAT_W-1:0] y_for(input int i);
      case (i)
         0:       return Y_A;
         1:       return Y_B;
         2:       return Y_U;
         default: return Y_D;
      endcase
   endfunction

   // Waits on negedges until rsp_valid rises or the budget runs out.
   task automatic wait_rsp(input int n0, output int n);
      n = n0;
      while (rsp_valid == '0 && n < n0 + 200) begin
         @(negedge clk);
         n++;
      end
      check("rsp_seen", rsp_valid != '0, 1'b1);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One complete job from IDLE; req raised at cycle 0.
   task automatic run_job(input int i, input logic [MAT_W-1:0] mat,
                          input logic [MAT_W-1:0] y_exp, input string tag);
      int n;
      int s0;
      @(negedge clk);
      req[i] = 1'b1;
      req_mat[i*MAT_W +: MAT_W] = mat;
      s0 = start_count;
      @(negedge clk);
      check({tag, "_gnt"}, gnt, oh(i));
      check({tag, "_start"}, eng_start, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      req[i] = 1'b0;
      req_mat[i*MAT_W +: MAT_W] = ~mat;
      @(negedge clk);
      check({tag, "_gnt_once"}, gnt, '0);
      check({tag, "_start_once"}, eng_start, 1'b0);
      check({tag, "_eng_x"}, eng_x, mat);
      wait_rsp(2, n);
      check({tag, "_latency"}, n, L + 2);
      check({tag, "_rsp_valid"}, rsp_valid, oh(i));
      check({tag, "_rsp_y"}, rsp_y, y_exp);
      check({tag, "_eng_x_hold"}, eng_x, mat);
      check({tag, "_starts"}, start_count - s0, 1);
      @(negedge clk);
      check({tag, "_rsp_done"}, rsp_valid, '0);
      check({tag, "_idle"}, busy, 1'b0);
      check({tag, "_y_hold"}, rsp_y, y_exp);
   endtask

   initial begin
      int n;
      int idle;
      int last_g;
      int s0;
      int g1;
      int r0;

      rst     = 1'b1;
      req     = '0;
      req_mat = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_start", eng_start, 1'b0);
      check("rst_rsp_y", rsp_y, '0);
      check("rst_eng_x", eng_x, '0);
      rst = 1'b0;

      // Single requester and uniform-row jobs.
      run_job(0, MAT_A, Y_A, "single");
      run_job(2, MAT_B, Y_B, "uniform");

      // Contention: all four held high from a fresh rr_ptr of 0.
      pulse_rst();
      s0      = start_count;
      req_mat = {MAT_D, MAT_U, MAT_B, MAT_A};
      req     = '1;
      last_g  = 0;
      for (int k = 0; k < 6; k++) begin
         n    = 0;
         idle = 0;
         while (gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
            if (!busy) idle++;
         end
         check("cont_gnt", gnt, oh(k % 4));
         check("cont_start", eng_start, 1'b1);
         if (k > 0) begin
            check("cont_gap", cyc - last_g, L + 3);
            check("cont_idle", idle, 1);
         end
         last_g = cyc;
         if (k == 5) req = '0;
         wait_rsp(0, n);
         check("cont_rsp_valid", rsp_valid, oh(k % 4));
         check("cont_rsp_y", rsp_y, y_for(k % 4));
      end
      check("cont_starts", start_count - s0, 6);

      // Withdrawal during WAIT, then a late arrival in the rsp_valid cycle.
      @(negedge clk);
      g1     = gnt_hits[1];
      req[0] = 1'b1;
      @(negedge clk);
      check("wd_gnt0", gnt, oh(0));
      req[0] = 1'b0;
      @(negedge clk);
      req[1] = 1'b1;
      @(negedge clk);
      req[1] = 1'b0;
      wait_rsp(3, n);
      check("wd_rsp_valid", rsp_valid, oh(0));
      req[3] = 1'b1;
      @(negedge clk);
      check("late_idle_gnt", gnt, '0);
      check("late_idle_busy", busy, 1'b0);
      @(negedge clk);
      check("late_gnt", gnt, oh(3));
      req[3] = 1'b0;
      wait_rsp(1, n);
      check("late_rsp_y", rsp_y, Y_D);
      check("wd_no_gnt1", gnt_hits[1] - g1, 0);

      // Reset while the engine is busy.
      @(negedge clk);
      req[0] = 1'b1;
      req_mat[0 +: MAT_W] = MAT_A;
      @(negedge clk);
      check("rw_gnt", gnt, oh(0));
      req[0] = 1'b0;
      @(negedge clk);
      r0  = rsp_hits[0];
      rst = 1'b1;
      @(negedge clk);
      check("rw_gnt_0", gnt, '0);
      check("rw_busy_0", busy, 1'b0);
      check("rw_start_0", eng_start, 1'b0);
      check("rw_rsp_valid_0", rsp_valid, '0);
      check("rw_rsp_y_0", rsp_y, '0);
      check("rw_eng_x_0", eng_x, '0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("rw_no_rsp", rsp_hits[0] - r0, 0);
      run_job(0, MAT_A, Y_A, "post_rst");

`ifdef SOFTMAX_ARB_TIMEOUT_EN
      // Watchdog: engine never finishes.
      eng_hang = 1'b1;
      @(negedge clk);
      req[1] = 1'b1;
      req_mat[MAT_W +: MAT_W] = MAT_B;
      @(negedge clk);
      check("to_gnt", gnt, oh(1));
      req[1] = 1'b0;
      @(negedge clk);
      wait_rsp(2, n);
      check("to_latency", n, 2 + TO);
      check("to_rsp_err", rsp_err, 1'b1);
      check("to_rsp_valid", rsp_valid, oh(1));
      check("to_rsp_y", rsp_y, '0);
      @(negedge clk);
      check("to_err_pulse", rsp_err, 1'b0);
      eng_hang = 1'b0;
      pulse_rst();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/softmax_engine_arbiter.md
Name: softmax_engine_arbiter

Overview:
Shares one softmax_4x4_rowwise engine (FP32 4x4 in, row-wise softmax 4x4 out, start/done_all handshake) among NREQ requesters, such as attention heads. Each requester is selected round-robin. The block latches the granted requester's matrix, launches the engine, waits for completion, and returns the result with a one-hot response strobe. It sits between the attention-score producers and the single softmax datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, element width (IEEE-754 single)
TIMEOUT, 2000000, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NREQ  per-requester job request (level)
req_mat  in  NREQ*16*DW  per-requester matrix; requester i occupies slice [i*512 +: 512]; element order X00..X33, X00 in the LSBs
gnt  out  NREQ  one-hot, one-cycle: the job is accepted and the matrix captured
rsp_valid  out  NREQ  one-hot, one-cycle: result for that requester is on rsp_y
rsp_y  out  16*DW  result matrix, Y00 in the LSBs
busy  out  1  high in every state except IDLE
eng_start  out  1  to engine start; one-cycle pulse
eng_x  out  16*DW  to engine X00..X33; driven from the internal x_reg
eng_done  in  1  from engine done_all
eng_y  in  16*DW  from engine Y00..Y33

Behaviour:
- Reset state: all outputs 0; x_reg=0, y_reg=0, rr_ptr=0, state=IDLE. Reset mid-job drops the job with no rsp_valid. The engine shares the same rst.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register id=pick, x_reg=req_mat[pick], and gnt=onehot(pick); go to LAUNCH.
  - If req == 0, stay in IDLE.
- LAUNCH (exactly 1 cycle): gnt and eng_start are high together; go to WAIT. eng_done is ignored here, since it may be stale from the previous job.
- WAIT:
  - On the first cycle with eng_done=1, set y_reg=eng_y and go to RESP.
  - eng_x holds x_reg stable for the whole job.
- RESP (exactly 1 cycle):
  - rsp_valid=onehot(id).
  - rr_ptr=(id+1) mod NREQ.
  - Go to IDLE.
- rsp_y always reflects y_reg and holds its value until the next capture.
- Minimum job: request to gnt is 1 cycle; a job with engine latency L completes in L+3 cycles; back-to-back throughput is one job per L+3 cycles.
- Requester rules:
  - Hold req and req_mat until gnt is seen, then drop req the next cycle.
  - Dropping req before gnt withdraws the job, with no gnt.
  - Keeping req high after gnt queues a new job, but the other active requesters are served first (fairness).
- Simultaneous events:
  - All req bits high: grants rotate 0,1,2,3,0...
  - req arriving during WAIT/RESP: waits for IDLE.
  - A new req in the same cycle as rsp_valid: arbitrated in the following IDLE cycle.
- Data is passed through unmodified; there is no FP arithmetic in this block.

Optional Feature:
- Macro: SOFTMAX_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit watchdog counts WAIT cycles.
  - If the count reaches TIMEOUT without eng_done, go to RESP with rsp_y forced to all-zero and an extra output rsp_err=1 for that one cycle.
  - The counter clears on entry to WAIT.
  - Because the engine may still be mid-job, a recovery reset is the system's responsibility.
- When not defined: no counter, no rsp_err port, and WAIT waits indefinitely.

Decomposition:
- softmax_pkg: DW; MAT_ELEMS=16; MAT_W=MAT_ELEMS*DW; fp32_t; mat_t (packed 16x fp32_t); arb_state_e {IDLE, LAUNCH, WAIT, RESP}; the FP32 constants 0x3E800000 (0.25) and 0x00000000 used by the bench.
- One sub-module, rr_pick: purely combinational (req, rr_ptr) -> (any, pick index, onehot).

Test Plan:
- Single requester:
  - Stimulus: req[0]=1 with every row {0,0.5,1,2} (00000000,3F000000,3F800000,40000000), real engine attached.
  - Expected: gnt=0001 one cycle later; eng_start pulses once; rsp_valid=0001; each row ≈ {0.0784,0.1292,0.2131,0.5793} ±1e-3, row sum 1.0±1e-3.
- Uniform row:
  - Stimulus: req[2]=1, row0={0,0,0,0}, other rows as above.
  - Expected: row0 = 3E800000 ×4 exactly; gnt=0100, rsp_valid=0100.
- Contention:
  - Stimulus: req=1111 held, re-requesting after each gnt.
  - Expected: grant order 0,1,2,3,0,1; exactly one eng_start per gnt; busy low for at most 1 cycle between jobs.
- Withdrawal and late arrival:
  - Stimulus: req[1] pulsed during WAIT then dropped; req[3] raised in the rsp_valid cycle.
  - Expected: no gnt for requester 1; gnt=1000 on the cycle after return to IDLE.
- Reset mid-WAIT:
  - Stimulus: assert rst 1 cycle while in WAIT.
  - Expected: next cycle all outputs 0, state IDLE, no rsp_valid; a fresh req[0] then completes normally.
- SOFTMAX_ARB_TIMEOUT_EN with TIMEOUT=50:
  - Stimulus: stub engine never asserts eng_done.
  - Expected: rsp_err and rsp_valid for that requester assert 50 cycles after WAIT entry, rsp_y=0.
